// File: rtl/data_mem.sv
// Word-addressed data memory for the MEM stage: synchronous writes, combinational reads,
// async active-low clear. Define DATAMEM_WRITE_FORWARD_EN to forward writeData on simultaneous read/write.
module data_mem #(
  parameter int size  = 32,
  parameter int depth = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            memRead,
  input  logic            memWrite,
  input  logic [size-1:0] address,
  input  logic [size-1:0] writeData,
  output logic [size-1:0] out
);

  localparam int IDX_W = $clog2(depth);

  logic [size-1:0]  mem_q [depth];
  logic [size-1:0]  mem_d [depth];
  logic [IDX_W-1:0] index;
  logic             in_range;

  // Byte offset bits are dropped; anything above the word index must be zero.
  assign index    = address[IDX_W+1:2];
  assign in_range = ((address >> (IDX_W + 2)) == '0);

  always_comb begin
    mem_d = mem_q;
    if (memWrite && in_range) begin
      mem_d[index] = writeData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    out = '0;
    if (memRead && reset && in_range) begin
`ifdef DATAMEM_WRITE_FORWARD_EN
      if (memWrite) begin
        out = writeData;
      end else begin
        out = mem_q[index];
      end
`else
      out = mem_q[index];
`endif
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem: reset, write/read-back, aliasing,
// range checks, simultaneous read/write and a full sweep.
module tb_data_mem;

  logic        clk;
  logic        reset;
  logic        memRead;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] out;

  int total = 0;
  int bad   = 0;

  data_mem #(.size(32), .depth(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .address   (address),
    .writeData (writeData),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic writeWord(input logic [31:0] addr, input logic [31:0] data);
    address   = addr;
    writeData = data;
    memWrite  = 1'b1;
    @(posedge clk);
    #1;
    memWrite  = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    memRead = 1'b1;
    address = addr;
    #1;
    check(tag, out, exp);
  endtask

  logic [31:0] simExp;

  initial begin
    reset     = 1'b0;
    memRead   = 1'b1;
    memWrite  = 1'b0;
    address   = 32'd0;
    writeData = 32'd0;
    #19;
    check("out_in_reset", out, 32'd0);
    #1;
    reset = 1'b1;

    readCheck("reset_rd0", 32'd0, 32'd0);
    readCheck("reset_rd4", 32'd4, 32'd0);
    readCheck("reset_rd252", 32'd252, 32'd0);

    memRead = 1'b0;
    writeWord(32'd0, 32'd2);
    readCheck("wr_rd0", 32'd0, 32'd2);
    memRead = 1'b0;
    #1;
    check("rd_disabled", out, 32'd0);

    readCheck("pre_reset_rd0", 32'd0, 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_out", out, 32'd0);
    memWrite  = 1'b1;
    writeData = 32'd9;
    @(posedge clk);
    #1;
    memWrite = 1'b0;
    reset    = 1'b1;
    readCheck("after_reset_rd0", 32'd0, 32'd0);

    memRead = 1'b0;
    writeWord(32'd6, 32'hDEADBEEF);
    readCheck("alias_rd4", 32'd4, 32'hDEADBEEF);
    readCheck("alias_rd7", 32'd7, 32'hDEADBEEF);

    memRead = 1'b0;
    writeWord(32'd256, 32'h0000_1111);
    readCheck("oor_rd256", 32'd256, 32'd0);
    readCheck("oor_no_alias_rd0", 32'd0, 32'd0);
    readCheck("oor_word1_intact", 32'd4, 32'hDEADBEEF);
    readCheck("oor_rd_high", 32'h8000_0004, 32'd0);

    memRead = 1'b0;
    writeWord(32'd8, 32'd5);
    memRead   = 1'b1;
    memWrite  = 1'b1;
    address   = 32'd8;
    writeData = 32'd7;
`ifdef DATAMEM_WRITE_FORWARD_EN
    simExp = 32'd7;
`else
    simExp = 32'd5;
`endif
    #1;
    check("rw_pre_edge", out, simExp);
    @(posedge clk);
    #1;
    memWrite = 1'b0;
    check("rw_post_edge", out, 32'd7);

    memRead = 1'b0;
    for (int i = 0; i < 64; i++) begin
      writeWord(32'(i * 4), 32'(i));
    end
    for (int i = 0; i < 64; i++) begin
      readCheck($sformatf("sweep_%0d", i), 32'(i * 4), 32'(i));
    end
    readCheck("sweep_oor", 32'd256, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
